// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded ID fields, forward sources, ALU operands and EX controls.
// Latency: none (wires only).
// Backpressure: stall/flush travel with the bundle; load_use_hazard returns toward ID.
interface id_ex_if;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src;
    logic        id_shift;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_mem_to_reg;
    logic        ex_illegal;
    logic        load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_rd, id_alu_ctrl, id_alu_src, id_shift,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_control, ex_store_data, ex_rd, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_illegal, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
               id_rs, id_rt, id_rd, id_alu_ctrl, id_alu_src, id_shift,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_control, ex_store_data, ex_rd, ex_valid,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_illegal, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB forwarding into the ALU operand muxes.
// Latency: one cycle ID->EX registers; operands combinational from registers and forward sources.
// Backpressure: stall holds the stage; flush or a load-use hazard loads a bubble instead.
module id_ex_stage (
    input  logic      clk,
    input  logic      rst,
    id_ex_if.slave    bus
);

    logic        ex_valid_q, ex_reg_write_q, ex_mem_read_q, ex_mem_write_q, ex_mem_to_reg_q;
    logic        ex_illegal_q, ex_alu_src_q, ex_shift_q;
    logic [3:0]  alu_control_q;
    logic [4:0]  ex_rs_q, ex_rt_q, ex_rd_q, ex_shamt_q;
    logic [31:0] ex_rs_data_q, ex_rt_data_q, ex_imm_q;
    logic [31:0] fwd_rs, fwd_rt;
    logic        hazard;
    logic        bubble;

    // Codes the ALU actually implements; anything else yields all-ones from the ALU.
    function automatic logic ctrl_illegal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0100, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010: ctrl_illegal = 1'b0;
            default:                   ctrl_illegal = 1'b1;
        endcase
    endfunction

    // Conservative load-use check: rt is compared even for instructions that ignore it.
    assign hazard = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) && bus.id_valid &&
                    ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt));
    assign bubble = bus.flush || hazard;

    // Stage register: bubble beats stall, stall beats capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_illegal_q    <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_shift_q      <= 1'b0;
            alu_control_q   <= 4'd0;
            ex_rs_q         <= 5'd0;
            ex_rt_q         <= 5'd0;
            ex_rd_q         <= 5'd0;
            ex_shamt_q      <= 5'd0;
            ex_rs_data_q    <= 32'd0;
            ex_rt_data_q    <= 32'd0;
            ex_imm_q        <= 32'd0;
        end else if (bubble) begin
            // Data fields are left alone; with every control bit low they have no effect.
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_illegal_q    <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_shift_q      <= 1'b0;
            alu_control_q   <= 4'd0;
        end else if (!bus.stall) begin
            ex_valid_q      <= bus.id_valid;
            ex_reg_write_q  <= bus.id_reg_write;
            ex_mem_read_q   <= bus.id_mem_read;
            ex_mem_write_q  <= bus.id_mem_write;
            ex_mem_to_reg_q <= bus.id_mem_to_reg;
            ex_illegal_q    <= bus.id_valid && ctrl_illegal(bus.id_alu_ctrl);
            ex_alu_src_q    <= bus.id_alu_src;
            ex_shift_q      <= bus.id_shift;
            alu_control_q   <= bus.id_alu_ctrl;
            ex_rs_q         <= bus.id_rs;
            ex_rt_q         <= bus.id_rt;
            ex_rd_q         <= bus.id_rd;
            ex_shamt_q      <= bus.id_shamt;
            ex_rs_data_q    <= bus.id_rs_data;
            ex_rt_data_q    <= bus.id_rt_data;
            ex_imm_q        <= bus.id_imm;
        end
    end

    // Forward muxes: the younger EX/MEM result wins over MEM/WB; $0 is never forwarded.
    always_comb begin
        fwd_rs = ex_rs_data_q;
        fwd_rt = ex_rt_data_q;
        if (bus.exmem_reg_write && (bus.exmem_rd == ex_rs_q) && (ex_rs_q != 5'd0))
            fwd_rs = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd == ex_rs_q) && (ex_rs_q != 5'd0))
            fwd_rs = bus.memwb_result;
        if (bus.exmem_reg_write && (bus.exmem_rd == ex_rt_q) && (ex_rt_q != 5'd0))
            fwd_rt = bus.exmem_result;
        else if (bus.memwb_reg_write && (bus.memwb_rd == ex_rt_q) && (ex_rt_q != 5'd0))
            fwd_rt = bus.memwb_result;
    end

    assign bus.alu_a           = ex_shift_q ? fwd_rt : fwd_rs;
    assign bus.alu_b           = ex_shift_q ? {27'd0, ex_shamt_q} :
                                 (ex_alu_src_q ? ex_imm_q : fwd_rt);
    assign bus.ex_store_data   = fwd_rt;
    assign bus.alu_control     = alu_control_q;
    assign bus.ex_rd           = ex_rd_q;
    assign bus.ex_valid        = ex_valid_q;
    assign bus.ex_reg_write    = ex_reg_write_q;
    assign bus.ex_mem_read     = ex_mem_read_q;
    assign bus.ex_mem_write    = ex_mem_write_q;
    assign bus.ex_mem_to_reg   = ex_mem_to_reg_q;
    assign bus.ex_illegal      = ex_illegal_q;
    assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, $0 guard, load-use, stall/flush, shift/illegal.
// Latency: checks registered outputs #1 after the rising edge, combinational ones #1 after driving.
// Backpressure: exercises stall, flush and the load-use bubble directly.
module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid      = 1'b0;
        bus.id_rs_data    = 32'd0;
        bus.id_rt_data    = 32'd0;
        bus.id_imm        = 32'd0;
        bus.id_shamt      = 5'd0;
        bus.id_rs         = 5'd0;
        bus.id_rt         = 5'd0;
        bus.id_rd         = 5'd0;
        bus.id_alu_ctrl   = 4'd0;
        bus.id_alu_src    = 1'b0;
        bus.id_shift      = 1'b0;
        bus.id_reg_write  = 1'b0;
        bus.id_mem_read   = 1'b0;
        bus.id_mem_write  = 1'b0;
        bus.id_mem_to_reg = 1'b0;
    endtask

    task automatic clear_fwd();
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = 5'd0;
        bus.exmem_result    = 32'd0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = 5'd0;
        bus.memwb_result    = 32'd0;
    endtask

    task automatic id_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [3:0] ctrl);
        clear_id();
        bus.id_valid     = 1'b1;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_rs_data   = rs_d;
        bus.id_rt_data   = rt_d;
        bus.id_alu_ctrl  = ctrl;
        bus.id_reg_write = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_id();
        clear_fwd();
        #12;
        check("reset ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("reset alu_control", {28'd0, bus.alu_control}, 32'd0);
        check("reset ex_illegal", {31'd0, bus.ex_illegal}, 32'd0);
        check("reset ex_rd", {27'd0, bus.ex_rd}, 32'd0);
        check("reset alu_a", bus.alu_a, 32'd0);
        check("reset alu_b", bus.alu_b, 32'd0);
        check("reset store", bus.ex_store_data, 32'd0);
        check("reset hazard", {31'd0, bus.load_use_hazard}, 32'd0);
        rst = 1'b0;

        // ADD rd=5, rs=3, rt=4 captured one edge later
        id_alu(5'd3, 5'd4, 5'd5, 32'h100, 32'h200, 4'b1000);
        tick();
        check("add alu_control", {28'd0, bus.alu_control}, 32'h8);
        check("add ex_rd", {27'd0, bus.ex_rd}, 32'd5);
        check("add ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("add alu_a nofwd", bus.alu_a, 32'h100);
        check("add alu_b nofwd", bus.alu_b, 32'h200);

        // Forward priority while the stage is held
        bus.stall = 1'b1;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h11;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'h22;
        #1 check("fwd exmem prio", bus.alu_a, 32'h11);
        bus.exmem_reg_write = 1'b0;
        #1 check("fwd memwb", bus.alu_a, 32'h22);
        bus.memwb_rd = 5'd4;
        #1 check("fwd rt memwb alu_a", bus.alu_a, 32'h100);
        check("fwd rt memwb alu_b", bus.alu_b, 32'h22);
        check("fwd rt store", bus.ex_store_data, 32'h22);
        clear_fwd();

        // Asynchronous reset mid-stream, away from any edge
        tick();
        check("hold before rst", {28'd0, bus.alu_control}, 32'h8);
        #2 rst = 1'b1;
        #1;
        check("midrst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("midrst alu_control", {28'd0, bus.alu_control}, 32'd0);
        check("midrst ex_rd", {27'd0, bus.ex_rd}, 32'd0);
        check("midrst alu_a", bus.alu_a, 32'd0);
        check("midrst hazard", {31'd0, bus.load_use_hazard}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.stall = 1'b0;

        // $0 guard
        id_alu(5'd0, 5'd2, 5'd6, 32'd0, 32'h33, 4'b1000);
        tick();
        bus.stall = 1'b1;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hDEAD;
        #1 check("zero guard alu_a", bus.alu_a, 32'd0);
        clear_fwd();
        bus.stall = 1'b0;

        // Load-use: lw rd=7 in EX, dependent SUB in ID
        id_alu(5'd1, 5'd7, 5'd7, 32'h40, 32'd0, 4'b1000);
        bus.id_alu_src = 1'b1; bus.id_mem_read = 1'b1; bus.id_mem_to_reg = 1'b1;
        tick();
        check("lw ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
        id_alu(5'd7, 5'd2, 5'd9, 32'h5, 32'h6, 4'b1001);
        #1 check("luh asserted", {31'd0, bus.load_use_hazard}, 32'd1);
        tick();
        check("bubble ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("bubble alu_control", {28'd0, bus.alu_control}, 32'd0);
        check("bubble mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
        check("luh cleared", {31'd0, bus.load_use_hazard}, 32'd0);
        tick();
        check("after bubble valid", {31'd0, bus.ex_valid}, 32'd1);
        check("after bubble ctrl", {28'd0, bus.alu_control}, 32'h9);
        check("after bubble rd", {27'd0, bus.ex_rd}, 32'd9);

        // Stall three cycles with a different instruction waiting in ID
        id_alu(5'd10, 5'd11, 5'd12, 32'h1, 32'h2, 4'b0001);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall ctrl", {28'd0, bus.alu_control}, 32'h9);
            check("stall rd", {27'd0, bus.ex_rd}, 32'd9);
        end
        bus.flush = 1'b1;
        tick();
        check("flush ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("flush reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
        check("flush ctrl", {28'd0, bus.alu_control}, 32'd0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Shift: A = rt, B = shamt
        id_alu(5'd0, 5'd6, 5'd8, 32'h0, 32'h80000001, 4'b0100);
        bus.id_shift = 1'b1; bus.id_shamt = 5'd4;
        tick();
        check("shift alu_a", bus.alu_a, 32'h80000001);
        check("shift alu_b", bus.alu_b, 32'd4);
        check("shift legal", {31'd0, bus.ex_illegal}, 32'd0);

        // Illegal and boundary codes
        id_alu(5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 4'b0101);
        tick();
        check("illegal 0101", {31'd0, bus.ex_illegal}, 32'd1);
        id_alu(5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 4'b1010);
        tick();
        check("legal 1010", {31'd0, bus.ex_illegal}, 32'd0);
        id_alu(5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 4'b1011);
        tick();
        check("illegal 1011", {31'd0, bus.ex_illegal}, 32'd1);
        bus.id_valid = 1'b0;
        tick();
        check("invalid no illegal", {31'd0, bus.ex_illegal}, 32'd0);
        check("invalid ex_valid", {31'd0, bus.ex_valid}, 32'd0);

        // Immediate operand select
        id_alu(5'd1, 5'd2, 5'd3, 32'h7, 32'h8, 4'b1000);
        bus.id_alu_src = 1'b1; bus.id_imm = 32'hFFFF_FFF0;
        tick();
        check("imm alu_b", bus.alu_b, 32'hFFFF_FFF0);
        check("imm store", bus.ex_store_data, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and EX-stage operand selector for the pipelined MIPS32 core. It captures decoded fields from the ID stage and resolves RAW hazards by forwarding from EX/MEM and MEM/WB. It drives the A, B and 4-bit Control inputs of the 32-bit ALU, and detects load-use hazards for the ID stage. It also handles pipeline hold (stall) and bubble insertion (flush or load-use).

## Interface
- No parameters; datapath fixed at 32 bits, register addresses 5 bits.
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all stage registers (downstream freeze)
- flush  in  1  replace incoming instruction with a bubble (branch redirect)
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  sign/zero-extended immediate
- id_shamt  in  5  shift amount
- id_rs, id_rt, id_rd  in  5  source and destination register numbers
- id_alu_ctrl  in  4  ALU Control code
- id_alu_src  in  1  1: B = immediate
- id_shift  in  1  1: A = rt operand, B = {27'b0, shamt}
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  pass-through controls
- exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forward source
- memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forward source
- alu_a, alu_b  out  32  ALU operands (combinational from stage registers and forward sources)
- alu_control  out  4  registered ALU Control
- ex_store_data  out  32  forwarded rt value for stores
- ex_rd  out  5; ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered
- ex_illegal  out  1  registered; valid instruction with a non-legal Control code
- load_use_hazard  out  1  combinational; ID must hold

## Operation
- Legal Control codes: 0000 AND, 0001 OR, 0100/0110/0111 shift, 1000 ADD, 1001 SUB, 1010 SLT. Every other code is illegal; the ALU outputs 32'hFFFFFFFF for these.
- Register update on each rising edge, with priority flush > load-use > stall > load:
  - flush or load_use_hazard: load a bubble. All control bits, ex_valid, ex_illegal and alu_control are 0; data fields are don't-care. flush overrides stall.
  - stall (no flush, no hazard): hold every register.
  - else: capture all id_* fields. ex_illegal = id_valid & illegal(id_alu_ctrl).
- Forwarding, evaluated per operand (rs, rt) against the registered register number src:
  - EX/MEM match (exmem_reg_write & exmem_rd == src & src != 0) → exmem_result.
  - else MEM/WB match (same conditions) → memwb_result.
  - else the registered register-file data.
  - EX/MEM has priority when both match. Register $0 is never forwarded.
- Operand select:
  - alu_a = id_shift ? fwd_rt : fwd_rs.
  - alu_b = id_shift ? {27'b0, shamt} : (alu_src ? imm : fwd_rt).
  - ex_store_data = fwd_rt always.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs | ex_rd == id_rt).
  - The check is conservative: id_rt is compared even when unused.

## Timing
- Latency: one cycle from ID inputs to registered outputs. alu_a, alu_b and ex_store_data follow the forward inputs in the same cycle, with no added register.
- Reset (asynchronous, takes effect immediately): all registers 0.
  - Resulting outputs: ex_valid=0, alu_control=0000, ex_illegal=0, ex_rd=0, alu_a=0, alu_b=0, ex_store_data=0, load_use_hazard=0.
- Reset mid-operation discards the in-flight instruction. The first capture occurs on the first rising edge after rst deasserts.
- A hazard bubble is inserted for exactly one cycle. On the next cycle the load has left EX (ex_mem_read=0), so the hazard clears unless a new load has been captured.
- flush and stall asserted together: a bubble is inserted and stall is ignored for that edge.

## Test plan
- Reset: assert rst mid-stream, with stage holding ctrl 1000 and rd=5 → all registered outputs 0 immediately, alu_a=0, load_use_hazard=0.
- Forward priority: EX has rs=3 (ADD). exmem_rd=3, exmem_result=0x11; memwb_rd=3, memwb_result=0x22 → alu_a=0x11. Drop exmem_reg_write → alu_a=0x22.
- $0 guard: rs=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xDEAD → alu_a = registered rs data (0).
- Load-use: EX holds lw with rd=7; ID presents an instruction with rs=7 → load_use_hazard=1. Next edge: ex_valid=0, alu_control=0000. Following edge: ID instruction captured.
- Stall/flush: stall=1 for 3 cycles → outputs unchanged. Assert stall=1 and flush=1 → next edge ex_valid=0, ex_reg_write=0.
- Shift/illegal: id_shift=1, rt data=0x80000001, shamt=4, ctrl 0100 → alu_a=0x80000001, alu_b=4. id_alu_ctrl=0101, id_valid=1 → ex_illegal=1 after one edge.
